// File: rtl/keypad_scanner_if.sv
// Keypad matrix and key hand-off signals between the scanner and its surroundings.
// slave: the scanner side; master: the keypad matrix plus the key consumer.
interface keypad_scanner_if;
  logic [2:0] col;
  logic [3:0] row_drive;
  logic       key_valid;
  logic [3:0] key_number;
  logic       key_ready;
  logic       pressed;
  logic       overrun;

  modport slave (
    input  col,
    input  key_ready,
    output row_drive,
    output key_valid,
    output key_number,
    output pressed,
    output overrun
  );

  modport master (
    output col,
    output key_ready,
    input  row_drive,
    input  key_valid,
    input  key_number,
    input  pressed,
    input  overrun
  );
endinterface

// File: rtl/keypad_scanner.sv
// Purpose: scans a 4x3 phone keypad, debounces a press and encodes it as digit 0-9.
// Latency: key_valid rises DEBOUNCE_CYCLES-1 edges after the first nonzero column sample.
// Backpressure: one-entry output register; a key arriving while it is full is dropped and overrun sticks.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic            clk,
  input  logic            reset,
  keypad_scanner_if.slave kp
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [7:0] SCAN_LAST = 8'(SCAN_CYCLES - 1);
  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] cap_q, cap_d;
  logic       accept;

  logic       key_ok;
  logic [3:0] key_code;
  logic       issue;
  logic       take;

  logic       key_vld_q;
  logic [3:0] key_dat_q;
  logic       ovr_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      row_q   <= 2'd0;
      cnt_q   <= 8'd0;
      cap_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  // Next-state logic; the row only moves on an idle dwell timeout or after a confirmed release
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    accept  = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (kp.col == 3'b000) begin
          if (cnt_q == SCAN_LAST) begin
            row_d = row_q + 2'd1;
            cnt_d = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cap_d   = kp.col;
          cnt_d   = 8'd1;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (kp.col == cap_q) begin
          if (cnt_q == DB_LAST) begin
            accept  = 1'b1;
            state_d = HELD;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = SCAN;
          cnt_d   = 8'd0;
        end
      end
      HELD: begin
        if (kp.col != 3'b000) begin
          cnt_d = 8'd0;
        end else if (cnt_q == DB_LAST) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    kp.row_drive = 4'b0001 << row_q;
    kp.pressed   = (state_q == HELD);
  end

  // Key map; '*', '#' and multi-column patterns have no code
  always_comb begin
    key_ok   = 1'b1;
    key_code = 4'd0;
    case ({row_q, cap_q})
      5'b00_001: key_code = 4'd1;
      5'b00_010: key_code = 4'd2;
      5'b00_100: key_code = 4'd3;
      5'b01_001: key_code = 4'd4;
      5'b01_010: key_code = 4'd5;
      5'b01_100: key_code = 4'd6;
      5'b10_001: key_code = 4'd7;
      5'b10_010: key_code = 4'd8;
      5'b10_100: key_code = 4'd9;
      5'b11_010: key_code = 4'd0;
      default:   key_ok   = 1'b0;
    endcase
  end

  assign issue = accept & key_ok;
  assign take  = key_vld_q & kp.key_ready;

  // A new key may replace the held one only on the edge the consumer takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      key_vld_q <= 1'b0;
      key_dat_q <= 4'd0;
      ovr_q     <= 1'b0;
    end else if (issue) begin
      if (!key_vld_q || kp.key_ready) begin
        key_vld_q <= 1'b1;
        key_dat_q <= key_code;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (take) begin
      key_vld_q <= 1'b0;
    end
  end

  assign kp.key_valid  = key_vld_q;
  assign kp.key_number = key_dat_q;
  assign kp.overrun    = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad contact matrix drives col from row_drive;
// directed tables and sequences, then random presses against a run-length reference model.
module tb_keypad_scanner;
  localparam int SCAN = 4;
  localparam int DB   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_ready = 1'b0;
  logic [2:0] contacts [4];
  logic [2:0] col_mux;
  int         vectors = 0;
  int         miscompares = 0;
  bit         seen_valid;

  keypad_scanner_if bus ();

  keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (bus)
  );

  always #5 clk = ~clk;

  // Contact matrix: a closed contact shows on col only while its row is driven
  always_comb begin
    col_mux = 3'b000;
    for (int r = 0; r < 4; r++)
      if (bus.row_drive[r] === 1'b1) col_mux = col_mux | contacts[r];
  end
  assign bus.col       = col_mux;
  assign bus.key_ready = key_ready;

  // Reference model in terms of run lengths of samples
  typedef enum {M_IDLE, M_CONFIRM, M_RELEASE} mmode_t;
  int km [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{-1, 0, -1}};
  mmode_t     m_mode = M_IDLE;
  int         m_row = 0, m_dwell = 0, m_run = 0, m_zero = 0, m_num = 0;
  logic [2:0] m_pat = 3'b000;
  bit         m_vld = 0, m_ovr = 0;

  function automatic int key_of(int row, logic [2:0] pat);
    if (!$onehot(pat)) return -1;
    for (int c = 0; c < 3; c++)
      if (pat[c]) return km[row][c];
    return -1;
  endfunction

  task automatic model_step(input logic [2:0] c, input bit rdy, input bit rst);
    int k;
    bit iss;
    k = -1;
    iss = 0;
    if (rst) begin
      m_mode = M_IDLE; m_row = 0; m_dwell = 0; m_run = 0; m_zero = 0;
      m_pat = 3'b000; m_vld = 0; m_ovr = 0; m_num = 0;
      return;
    end
    case (m_mode)
      M_IDLE:
        if (c == 3'b000) begin
          m_dwell++;
          if (m_dwell == SCAN) begin m_row = (m_row + 1) % 4; m_dwell = 0; end
        end else begin
          m_pat = c; m_run = 1; m_mode = M_CONFIRM;
        end
      M_CONFIRM:
        if (c == m_pat) begin
          m_run++;
          if (m_run == DB) begin
            m_mode = M_RELEASE; m_zero = 0;
            k = key_of(m_row, m_pat);
            iss = (k >= 0);
          end
        end else begin
          m_mode = M_IDLE; m_dwell = 0;
        end
      default:
        if (c != 3'b000) m_zero = 0;
        else begin
          m_zero++;
          if (m_zero == DB) begin m_mode = M_IDLE; m_row = (m_row + 1) % 4; m_dwell = 0; end
        end
    endcase
    if (iss) begin
      if (!m_vld || rdy) begin m_vld = 1; m_num = k; end
      else m_ovr = 1;
    end else if (m_vld && rdy) begin
      m_vld = 0;
    end
  endtask

  task automatic step();
    logic [2:0] c;
    bit r, q;
    c = contacts[m_row];
    q = key_ready;
    r = reset;
    @(posedge clk);
    model_step(c, q, r);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".row_drive"},  32'(bus.row_drive), 1);
    chk({tag, ".key_valid"},  32'(bus.key_valid), 0);
    chk({tag, ".key_number"}, 32'(bus.key_number), 0);
    chk({tag, ".pressed"},    32'(bus.pressed), 0);
    chk({tag, ".overrun"},    32'(bus.overrun), 0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".row_drive"}, 32'(bus.row_drive), 1 << m_row);
    chk({tag, ".key_valid"}, 32'(bus.key_valid), 32'(m_vld));
    if (m_vld) chk({tag, ".key_number"}, 32'(bus.key_number), m_num);
    chk({tag, ".pressed"},   32'(bus.pressed), (m_mode == M_RELEASE) ? 1 : 0);
    chk({tag, ".overrun"},   32'(bus.overrun), 32'(m_ovr));
  endtask

  task automatic wait_pressed(input bit val, input int max_cyc, input string name);
    int n;
    n = 0;
    while (bus.pressed !== val && n < max_cyc) begin
      step();
      n++;
      if (bus.key_valid === 1'b1) seen_valid = 1;
    end
    chk(name, 32'(bus.pressed), 32'(val));
  endtask

  task automatic do_reset();
    foreach (contacts[r]) contacts[r] = 3'b000;
    key_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    int         row;
    logic [2:0] pat;
    bit         exp_valid;
    int         exp_num;
  } vec_t;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t       tbl [16];
    int         pulses, last_num, hold, sel, prow;
    logic [2:0] ppat;
    bit         pact;

    tbl = '{
      '{0, 3'b001, 1'b1, 1}, '{0, 3'b010, 1'b1, 2}, '{0, 3'b100, 1'b1, 3},
      '{1, 3'b001, 1'b1, 4}, '{1, 3'b010, 1'b1, 5}, '{1, 3'b100, 1'b1, 6},
      '{2, 3'b001, 1'b1, 7}, '{2, 3'b010, 1'b1, 8}, '{2, 3'b100, 1'b1, 9},
      '{3, 3'b010, 1'b1, 0}, '{3, 3'b001, 1'b0, 0}, '{3, 3'b100, 1'b0, 0},
      '{0, 3'b011, 1'b0, 0}, '{1, 3'b111, 1'b0, 0}, '{2, 3'b110, 1'b0, 0},
      '{3, 3'b101, 1'b0, 0}
    };

    // Reset state and idle sweep
    foreach (contacts[r]) contacts[r] = 3'b000;
    reset = 1'b1;
    step();
    step();
    check_reset("rst");
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("sweep.row_drive", 32'(bus.row_drive), 1 << ((k / 4) % 4));
      chk("sweep.key_valid", 32'(bus.key_valid), 0);
    end

    // Every key position, legal and illegal
    for (int i = 0; i < 16; i++) begin
      do_reset();
      seen_valid = 0;
      contacts[tbl[i].row] = tbl[i].pat;
      wait_pressed(1'b1, 100, $sformatf("tbl%0d.press", i));
      chk($sformatf("tbl%0d.key_valid", i), 32'(bus.key_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d.key_number", i), 32'(bus.key_number), tbl[i].exp_num);
      for (int k = 0; k < 12; k++) begin
        step();
        if (bus.key_valid === 1'b1) seen_valid = 1;
      end
      contacts[tbl[i].row] = 3'b000;
      wait_pressed(1'b0, 100, $sformatf("tbl%0d.release", i));
      chk($sformatf("tbl%0d.seen_valid", i), 32'(seen_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d.row_after", i), 32'(bus.row_drive), 1 << ((tbl[i].row + 1) % 4));
      chk($sformatf("tbl%0d.overrun", i), 32'(bus.overrun), 0);
    end

    // Press "5" with exact latency and release timing; detection is at edge 5 after reset
    do_reset();
    key_ready = 1'b1;
    contacts[1] = 3'b010;
    for (int k = 1; k <= 35; k++) begin
      if (k == 25) contacts[1] = 3'b000;
      step();
      chk("p5.key_valid", 32'(bus.key_valid), (k == 12) ? 1 : 0);
      if (k == 12) chk("p5.key_number", 32'(bus.key_number), 5);
      chk("p5.pressed", 32'(bus.pressed), (k >= 12 && k < 32) ? 1 : 0);
      chk("p5.row_drive", 32'(bus.row_drive), (k < 4) ? 1 : ((k < 32) ? 2 : 4));
    end

    // Bouncing "0" followed by a stable window
    do_reset();
    key_ready = 1'b1;
    pulses = 0;
    last_num = -1;
    for (int k = 0; k < 30; k++) begin
      contacts[3] = (((k / 3) % 2) == 0) ? 3'b010 : 3'b000;
      step();
      if (bus.key_valid === 1'b1) pulses++;
    end
    chk("bounce.no_key", 32'(pulses), 0);
    contacts[3] = 3'b010;
    for (int k = 0; k < 30; k++) begin
      if (k == 10) contacts[3] = 3'b000;
      step();
      if (bus.key_valid === 1'b1) begin pulses++; last_num = int'(bus.key_number); end
    end
    chk("bounce.one_key", 32'(pulses), 1);
    chk("bounce.key_number", 32'(last_num), 0);

    // Overrun: "1" held unread, "9" dropped
    do_reset();
    contacts[0] = 3'b001; wait_pressed(1'b1, 100, "ovr.p1");
    contacts[0] = 3'b000; wait_pressed(1'b0, 100, "ovr.r1");
    contacts[2] = 3'b100; wait_pressed(1'b1, 100, "ovr.p9");
    contacts[2] = 3'b000; wait_pressed(1'b0, 100, "ovr.r9");
    chk("ovr.key_valid", 32'(bus.key_valid), 1);
    chk("ovr.key_number", 32'(bus.key_number), 1);
    chk("ovr.overrun", 32'(bus.overrun), 1);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    chk("ovr.drop_valid", 32'(bus.key_valid), 0);
    chk("ovr.sticky", 32'(bus.overrun), 1);

    // key_ready pulsed on the exact load edge of "9"
    do_reset();
    contacts[0] = 3'b001; wait_pressed(1'b1, 100, "edge.p1");
    contacts[0] = 3'b000; wait_pressed(1'b0, 100, "edge.r1");
    chk("edge.row_drive", 32'(bus.row_drive), 2);
    contacts[2] = 3'b100;
    repeat (11) step();
    chk("edge.pre_valid", 32'(bus.key_valid), 1);
    chk("edge.pre_pressed", 32'(bus.pressed), 0);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    chk("edge.key_valid", 32'(bus.key_valid), 1);
    chk("edge.key_number", 32'(bus.key_number), 9);
    chk("edge.overrun", 32'(bus.overrun), 0);
    chk("edge.pressed", 32'(bus.pressed), 1);

    // Reset mid-debounce and mid-hold while a key is held
    do_reset();
    contacts[0] = 3'b001; wait_pressed(1'b1, 100, "rdb.p1");
    contacts[0] = 3'b000; wait_pressed(1'b0, 100, "rdb.r1");
    contacts[1] = 3'b010;
    repeat (3) step();
    chk("rdb.pre_valid", 32'(bus.key_valid), 1);
    reset = 1'b1;
    step();
    check_reset("rdb");
    reset = 1'b0;
    contacts[1] = 3'b000;
    contacts[0] = 3'b001; wait_pressed(1'b1, 100, "rhd.p1");
    repeat (3) step();
    chk("rhd.pre_valid", 32'(bus.key_valid), 1);
    reset = 1'b1;
    step();
    check_reset("rhd");
    reset = 1'b0;

    // Random presses, bounces, illegal patterns, ready and resets
    do_reset();
    hold = 0; pact = 0; prow = 0; ppat = 3'b000;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        foreach (contacts[r]) contacts[r] = 3'b000;
        sel = int'($urandom_range(0, 99));
        if (sel < 45) begin
          pact = 0;
          hold = int'($urandom_range(1, 30));
        end else begin
          pact = 1;
          prow = int'($urandom_range(0, 3));
          ppat = (sel < 92) ? 3'(3'b001 << $urandom_range(0, 2)) : 3'($urandom_range(1, 7));
          hold = int'($urandom_range(1, 50));
        end
      end else begin
        hold--;
      end
      if (pact) contacts[prow] = ($urandom_range(0, 9) == 0) ? 3'b000 : ppat;
      key_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 599) == 0);
      step();
      check_model("rand");
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scan controller for the 4-row × 3-column phone keypad that feeds the keypad decode logic. Drives one row at a time, senses the three columns, debounces a press, and encodes it as a digit 0–9. Waits for release before scanning on, and presents each key to the consumer through a one-entry valid/ready output register.

## Interface
- `SCAN_CYCLES`, default 4: clocks each row stays driven while idle (legal range 1–255).
- `DEBOUNCE_CYCLES`, default 8: consecutive identical samples needed to accept a press or a release (legal range 2–255).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock, one reset, no other async paths.
- `col`  in  3  column sense: bit 0 = column a, bit 1 = b, bit 2 = c; 1 = contact closed on the driven row.
- `row_drive`  out  4  one-hot row drive: bit 0 = row d, 1 = e, 2 = f, 3 = g.
- `key_valid`  out  1  the held key code is valid.
- `key_number`  out  4  digit 0–9, binary; meaningful only while `key_valid` is high.
- `key_ready`  in  1  consumer accepts the key on any edge where `key_valid` and `key_ready` are both high.
- `pressed`  out  1  high while in HELD.
- `overrun`  out  1  sticky; a legal key was dropped because the output register was full.

## Operation
- Key map, by row and column: d gives a=1, b=2, c=3. e gives 4, 5, 6. f gives 7, 8, 9. g gives b=0.
- Illegal patterns produce no key but are still debounced and must be released:
  - g with a (`*`) or g with c (`#`);
  - any `col` with more than one bit set.
- Internal state: FSM {SCAN, DEBOUNCE, HELD}, 2-bit row index, 8-bit dwell/debounce counter, 3-bit captured column pattern `cap`.
- SCAN:
  - If `col`==0: counter increments each cycle. When it reaches `SCAN_CYCLES`-1, the row index advances (3 wraps to 0) and the counter clears.
  - If `col`!=0: `cap`<=`col`, counter<=1, go to DEBOUNCE. The row does not advance.
- DEBOUNCE (row held):
  - If `col`==`cap` and counter==`DEBOUNCE_CYCLES`-1: accept the press and go to HELD with counter cleared. If the pattern is legal, issue it to the output register.
  - If `col`==`cap` otherwise: counter increments.
  - If `col`!=`cap`: bounce. Return to SCAN on the same row with counter cleared; no key.
- HELD (row held):
  - If `col`==0: counter increments; a nonzero `col` clears it.
  - When counter reaches `DEBOUNCE_CYCLES`-1 with `col`==0: go to SCAN, advance the row, clear counter.
- Output register, on each key issue:
  - Register empty, or being consumed on the same edge: `key_number` loads and `key_valid`=1.
  - Otherwise: the key is dropped, `overrun`<=1, and the held key is unchanged.
- `key_valid` clears on a `key_valid`&`key_ready` edge unless a key is loaded on that same edge.

## Timing
- Reset values:
  - state SCAN, row index 0, `row_drive`=4'b0001, counter 0, `cap` 0;
  - `key_valid` 0, `key_number` 0, `pressed` 0, `overrun` 0.
- Reset asserted mid-debounce or mid-hold aborts the operation and discards any held key.
- `row_drive` and `pressed` are registered state decodes; all outputs are registers, with no combinational path from `col` or `key_ready`.
- Idle row period is `SCAN_CYCLES` clocks. A full sweep is 4×`SCAN_CYCLES` clocks (16 at default).
- Press latency:
  - SCAN first sees `col`!=0 at edge t. If `col` stays constant, `key_valid` is high after edge t+`DEBOUNCE_CYCLES`-1.
  - Total `DEBOUNCE_CYCLES` matching samples, counting the SCAN sample.
- Release latency: `row_drive` advances after the `DEBOUNCE_CYCLES`-th consecutive zero sample in HELD.
- `key_ready` may be held high permanently; a key then stays valid for exactly one cycle.
- `col` is assumed synchronized upstream.

## Test plan
- Reset, no press, defaults:
  - `row_drive` sequence is 0001 (4 clk), 0010, 0100, 1000, then 0001 again at clk 16;
  - `key_valid`=0 throughout.
- Press "5" (`col`=3'b010 while `row_drive`=0010), held 20 clk, `key_ready`=1:
  - `key_valid` pulses one cycle with `key_number`=5 exactly 7 edges after first detection;
  - `pressed` stays high until 8 zero samples after release, then `row_drive`=0100.
- Bounce: press "0" on row g with `col` toggling 010/000 every 3 clk, then stable 10 clk:
  - no key during bouncing;
  - exactly one key with `key_number`=0 after the stable window.
- Illegal keys, `key_ready`=1:
  - `*` (row g, `col`=001) held 12 clk: no `key_valid`, `pressed`=1, scan resumes after release;
  - `col`=3'b011 on row d: same behaviour.
- Overrun: `key_ready`=0; press and release "1", then press "9":
  - `key_number` stays 1 and `overrun`=1;
  - raising `key_ready` drops `key_valid` next cycle;
  - repeat with `key_ready` pulsed on the exact load edge of "9": `key_number`=9, `key_valid` stays 1, no overrun.
- Reset asserted mid-DEBOUNCE and mid-HELD with `key_valid`=1: all outputs return to reset values on the next edge.
